// File: rtl/xram_arb_pkg.sv
// Shared types and helpers for the XRAM port arbiter
// and the reusable request picker.
package xram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xram_rr_pick.sv
// Combinational request picker: fixed priority (index 0 first)
// or round-robin starting just after the last grant.
module xram_rr_pick
    import xram_arb_pkg::*;
#(
    parameter int NCH = 3
) (
    input  logic [NCH-1:0]          i_req,
    input  logic [idx_w(NCH)-1:0]   i_last,
    input  logic                    i_rr,
    output logic                    o_valid,
    output logic [idx_w(NCH)-1:0]   o_idx
);

    localparam int IW = idx_w(NCH);
    localparam logic [IW:0] LP_N = (IW+1)'(NCH);

    logic [2*NCH-1:0] w_dbl;
    logic [NCH-1:0]   w_rot;
    logic [IW:0]      w_base;
    logic [IW:0]      w_off;
    logic [IW:0]      w_sum;

    assign w_dbl   = {i_req, i_req};
    assign o_valid = |i_req;

    // Rotate so the search start sits at bit 0, then take the lowest set bit.
    always_comb begin
        w_base = '0;
        if (i_rr) begin
            w_base = {1'b0, i_last} + 1'b1;
            if (w_base >= LP_N) begin
                w_base = '0;
            end
        end
        w_rot = NCH'(w_dbl >> w_base);
        w_off = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (IW+1)'(k);
            end
        end
        w_sum = w_base + w_off;
        if (w_sum >= LP_N) begin
            w_sum = w_sum - LP_N;
        end
        o_idx = IW'(w_sum);
    end

endmodule

// File: rtl/xram_port_arbiter.sv
// XRAM port arbiter: merges NCH requesters onto one strobe/ack bus
// with fixed or round-robin grant and an optional ack timeout.
module xram_port_arbiter
    import xram_arb_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_i,
    input  logic [NCH-1:0]    we_i,
    input  logic [NCH*AW-1:0] adr_i,
    input  logic [NCH*DW-1:0] wdat_i,
    output logic [NCH-1:0]    wait_o,
    output logic [NCH-1:0]    done_o,
    output logic [NCH-1:0]    err_o,
    output logic [DW-1:0]     rdat_o,
    output logic              dstb_o,
    output logic              dwe_o,
    output logic [AW-1:0]     dadr_o,
    output logic [DW-1:0]     ddat_o,
    input  logic              dack_i,
    input  logic [DW-1:0]     ddat_i
);

    localparam int IW = idx_w(NCH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LP_LIM  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] LP_LAST = IW'(NCH - 1);
    localparam logic          LP_RR   = (RR_MODE == MODE_RR);

    arb_state_e r_state;
    arb_state_e w_state_n;

    logic [AW-1:0]  w_adr [NCH];
    logic [DW-1:0]  w_wdat [NCH];
    logic           w_pick_vld;
    logic [IW-1:0]  w_pick_idx;
    logic           w_grant;
    logic           w_ack;
    logic           w_to;
    logic           w_lim;

    logic           r_dstb;
    logic           r_dwe;
    logic [AW-1:0]  r_dadr;
    logic [DW-1:0]  r_ddat;
    logic [DW-1:0]  r_rdat;
    logic [NCH-1:0] r_done;
    logic [NCH-1:0] r_err;
    logic [TW-1:0]  r_cnt;
    logic [IW-1:0]  r_gidx;
    logic [IW-1:0]  r_last;

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign w_adr[g]  = adr_i[g*AW +: AW];
        assign w_wdat[g] = wdat_i[g*DW +: DW];
    end

    xram_rr_pick #(
        .NCH(NCH)
    ) u_pick (
        .i_req  (req_i),
        .i_last (r_last),
        .i_rr   (LP_RR),
        .o_valid(w_pick_vld),
        .o_idx  (w_pick_idx)
    );

    assign w_lim = (TIMEOUT > 0) && (r_cnt == LP_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // An ack in the limit cycle takes precedence over the timeout.
    always_comb begin
        w_state_n = r_state;
        w_grant   = 1'b0;
        w_ack     = 1'b0;
        w_to      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_grant   = 1'b1;
                    w_state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (dack_i) begin
                    w_ack     = 1'b1;
                    w_state_n = DONE;
                end else if (w_lim) begin
                    w_to      = 1'b1;
                    w_state_n = DONE;
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dstb <= 1'b0;
            r_dwe  <= 1'b0;
            r_dadr <= '0;
            r_ddat <= '0;
            r_rdat <= '0;
            r_done <= '0;
            r_err  <= '0;
            r_cnt  <= '0;
            r_gidx <= '0;
            r_last <= LP_LAST;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            if (w_grant) begin
                r_gidx <= w_pick_idx;
                r_last <= w_pick_idx;
                r_dadr <= w_adr[w_pick_idx];
                r_ddat <= w_wdat[w_pick_idx];
                r_dwe  <= we_i[w_pick_idx];
                r_dstb <= 1'b1;
                r_cnt  <= '0;
            end
            if (w_ack || w_to) begin
                r_dstb         <= 1'b0;
                r_done[r_gidx] <= 1'b1;
                r_cnt          <= '0;
            end else if (r_state == ACCESS && TIMEOUT > 0) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_ack && !r_dwe) begin
                r_rdat <= ddat_i;
            end
            if (w_to) begin
                r_err[r_gidx] <= 1'b1;
            end
        end
    end

    assign wait_o = req_i & ~r_done;
    assign done_o = r_done;
    assign err_o  = r_err;
    assign rdat_o = r_rdat;
    assign dstb_o = r_dstb;
    assign dwe_o  = r_dwe;
    assign dadr_o = r_dadr;
    assign ddat_o = r_ddat;

endmodule

// File: tb/tb_xram_port_arbiter.sv
// Bench for xram_port_arbiter: fixed-priority instance with timeout
// and round-robin instance, checked against a transaction-level model.
module tb_xram_port_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 16;
    localparam int DW  = 8;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] adr;
    logic [NCH*DW-1:0] wdat;
    logic              dack;
    logic [DW-1:0]     ddat;

    logic [NCH-1:0] fx_wait, fx_done, fx_err, rr_wait, rr_done, rr_err;
    logic [DW-1:0]  fx_rdat, rr_rdat, fx_ddat, rr_ddat;
    logic [AW-1:0]  fx_dadr, rr_dadr;
    logic           fx_dstb, rr_dstb, fx_dwe, rr_dwe;

    bit sel;
    logic [NCH-1:0] o_wait, o_done, o_err;
    logic [DW-1:0]  o_rdat, o_ddat;
    logic [AW-1:0]  o_dadr;
    logic           o_dstb, o_dwe;

    int errors;
    int checks;
    int m_last;
    logic [DW-1:0] m_rdat;

    xram_port_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(5)
    ) u_fx (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .adr_i(adr),
        .wdat_i(wdat), .wait_o(fx_wait), .done_o(fx_done), .err_o(fx_err),
        .rdat_o(fx_rdat), .dstb_o(fx_dstb), .dwe_o(fx_dwe),
        .dadr_o(fx_dadr), .ddat_o(fx_ddat), .dack_i(dack), .ddat_i(ddat)
    );

    xram_port_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(0)
    ) u_rr (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .adr_i(adr),
        .wdat_i(wdat), .wait_o(rr_wait), .done_o(rr_done), .err_o(rr_err),
        .rdat_o(rr_rdat), .dstb_o(rr_dstb), .dwe_o(rr_dwe),
        .dadr_o(rr_dadr), .ddat_o(rr_ddat), .dack_i(dack), .ddat_i(ddat)
    );

    assign o_wait = sel ? rr_wait : fx_wait;
    assign o_done = sel ? rr_done : fx_done;
    assign o_err  = sel ? rr_err  : fx_err;
    assign o_rdat = sel ? rr_rdat : fx_rdat;
    assign o_ddat = sel ? rr_ddat : fx_ddat;
    assign o_dadr = sel ? rr_dadr : fx_dadr;
    assign o_dstb = sel ? rr_dstb : fx_dstb;
    assign o_dwe  = sel ? rr_dwe  : fx_dwe;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    // Winner by the arbitration rules: lowest index, or first set
    // bit scanning upward (with wrap) from the channel after the last grant.
    function automatic int pick(input logic [NCH-1:0] rq, input bit rr,
                                input int last);
        int s;
        s = rr ? (last + 1) % NCH : 0;
        for (int k = 0; k < NCH; k++) begin
            if (rq[(s + k) % NCH]) return (s + k) % NCH;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        dack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_last = NCH - 1;
        m_rdat = '0;
    endtask

    // One transaction starting in an IDLE cycle; ack in access cycle d.
    task automatic frame(input logic [NCH-1:0] rq, input logic [NCH-1:0] wev,
                         input logic [NCH*AW-1:0] adv,
                         input logic [NCH*DW-1:0] wdv, input int d,
                         input logic [DW-1:0] rd, input logic [NCH-1:0] drop);
        int w;
        logic [NCH-1:0] dexp;
        w      = pick(rq, sel, m_last);
        m_last = w;
        req    = rq;
        we     = wev;
        adr    = adv;
        wdat   = wdv;
        dack   = 1'b0;
        ddat   = DW'($urandom);
        @(negedge clk);
        checks++;
        if (o_dstb !== 1'b0 || o_wait !== rq) begin
            errors++;
            $display("FAIL idle: dstb=%b wait=%b, want dstb=0 wait=%b",
                     o_dstb, o_wait, rq);
        end
        for (int k = 1; k <= d; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) req = rq & ~drop;
            if (k == d) begin
                dack = 1'b1;
                ddat = rd;
            end
            @(negedge clk);
            checks++;
            if (o_dstb !== 1'b1 || o_dwe !== wev[w] ||
                o_dadr !== adv[w*AW +: AW] || o_ddat !== wdv[w*DW +: DW] ||
                o_done !== '0 || o_err !== '0 || o_wait !== req) begin
                errors++;
                $display("FAIL access ch%0d c%0d: stb=%b we=%b a=%h d=%h done=%b wait=%b, want 1 %b %h %h 000 %b",
                         w, k, o_dstb, o_dwe, o_dadr, o_ddat, o_done, o_wait,
                         wev[w], adv[w*AW +: AW], wdv[w*DW +: DW], req);
            end
        end
        @(posedge clk);
        #1;
        dack = 1'b0;
        ddat = DW'($urandom);
        @(negedge clk);
        dexp = NCH'(1) << w;
        if (!wev[w]) m_rdat = rd;
        checks++;
        if (o_done !== dexp || o_err !== '0 || o_dstb !== 1'b0 ||
            o_rdat !== m_rdat || o_wait !== (req & ~dexp)) begin
            errors++;
            $display("FAIL done: done=%b err=%b stb=%b rdat=%h wait=%b, want %b 000 0 %h %b",
                     o_done, o_err, o_dstb, o_rdat, o_wait, dexp, m_rdat,
                     req & ~dexp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 3'b111;
        we   = 3'b111;
        adr  = '1;
        wdat = '1;
        dack = 1'b1;
        ddat = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (fx_dstb !== 1'b0 || fx_dwe !== 1'b0 || fx_dadr !== '0 ||
            fx_ddat !== '0 || fx_rdat !== '0 || fx_done !== '0 ||
            fx_err !== '0 || rr_dstb !== 1'b0 || rr_done !== '0) begin
            errors++;
            $display("FAIL reset: stb=%b we=%b a=%h d=%h r=%h done=%b err=%b, want all 0",
                     fx_dstb, fx_dwe, fx_dadr, fx_ddat, fx_rdat, fx_done, fx_err);
        end
        checks++;
        if (fx_wait !== 3'b111) begin
            errors++;
            $display("FAIL reset_wait: wait=%b, want 111", fx_wait);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        sel = 0;
        frame(3'b001, 3'b000, {16'h5555, 16'h6666, 16'h1234},
              {8'h11, 8'h22, 8'h33}, 1, 8'hA5, 3'b000);
    endtask

    task automatic test_fixed_contention();
        do_reset();
        sel = 0;
        frame(3'b110, 3'b000, 48'h2222_1111_0000, 24'h030201, 1, 8'h41, 3'b000);
        frame(3'b110, 3'b000, 48'h2222_1111_0000, 24'h030201, 2, 8'h42, 3'b000);
        frame(3'b100, 3'b000, 48'h2222_1111_0000, 24'h030201, 1, 8'h43, 3'b000);
    endtask

    task automatic test_rr_contention();
        do_reset();
        sel = 1;
        repeat (4) begin
            frame(3'b111, 3'b000, 48'hCCCC_BBBB_AAAA, 24'h030201, 1,
                  DW'($urandom), 3'b000);
        end
    endtask

    task automatic test_write_delay();
        do_reset();
        sel = 0;
        frame(3'b001, 3'b000, 48'h0, 24'h0, 1, 8'h5A, 3'b000);
        frame(3'b100, 3'b100, {16'h00FF, 16'h7777, 16'h8888},
              {8'h3C, 8'h99, 8'h88}, 4, 8'hE7, 3'b000);
    endtask

    task automatic test_timeout();
        do_reset();
        sel  = 0;
        req  = 3'b010;
        we   = 3'b000;
        adr  = 48'h0000_4321_0000;
        wdat = '0;
        dack = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (o_dstb !== 1'b1 || o_err !== '0 || o_done !== '0) begin
                errors++;
                $display("FAIL to_wait c%0d: stb=%b err=%b done=%b, want 1 000 000",
                         k, o_dstb, o_err, o_done);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (o_err !== 3'b010 || o_done !== 3'b010 || o_dstb !== 1'b0 ||
            o_rdat !== m_rdat) begin
            errors++;
            $display("FAIL timeout: err=%b done=%b stb=%b rdat=%h, want 010 010 0 %h",
                     o_err, o_done, o_dstb, o_rdat, m_rdat);
        end
        @(posedge clk);
        #1;
        m_last = 1;
        frame(3'b010, 3'b000, 48'h0000_4321_0000, 24'h0, 5, 8'hC3, 3'b000);
    endtask

    task automatic test_reset_mid();
        do_reset();
        sel  = 0;
        req  = 3'b001;
        we   = 3'b000;
        adr  = 48'h1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        dack = 1'b1;
        ddat = 8'hA5;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req  = '0;
        @(negedge clk);
        checks++;
        if (o_dstb !== 1'b0 || o_done !== '0 || o_err !== '0 ||
            o_rdat !== '0) begin
            errors++;
            $display("FAIL rst_mid: stb=%b done=%b err=%b rdat=%h, want 0 000 000 00",
                     o_dstb, o_done, o_err, o_rdat);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (o_dstb !== 1'b0 || o_done !== '0) begin
            errors++;
            $display("FAIL stray_ack: stb=%b done=%b, want 0 000",
                     o_dstb, o_done);
        end
        @(posedge clk);
        #1;
        dack   = 1'b0;
        m_last = NCH - 1;
        m_rdat = '0;
        frame(3'b010, 3'b000, 48'h0000_ABCD_0000, 24'h0, 1, 8'h77, 3'b000);
    endtask

    task automatic test_random();
        for (int m = 0; m < 2; m++) begin
            do_reset();
            sel = (m == 1);
            repeat (40) begin
                frame(NCH'($urandom_range(1, 7)), NCH'($urandom),
                      {16'($urandom), 16'($urandom), 16'($urandom)},
                      24'($urandom), $urandom_range(1, 4), DW'($urandom),
                      NCH'($urandom));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sel    = 0;
        rst    = 1'b1;
        req    = '0;
        we     = '0;
        adr    = '0;
        wdat   = '0;
        dack   = 1'b0;
        ddat   = '0;
        m_last = NCH - 1;
        m_rdat = '0;
        test_reset();
        test_single_read();
        test_fixed_contention();
        test_rr_contention();
        test_write_delay();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xram_port_arbiter.md
# xram_port_arbiter

Parametrised external-data-memory (XRAM) port arbiter for the 8051 core, the next generation of the single-requester XRAM path in the three-port memory interface. Merges NCH independent requesters (e.g. MOVX data, instruction fetch overflow, debug/DMA) onto one strobe/ack external bus. Provides selectable fixed-priority or round-robin arbitration, an optional ack timeout, and per-channel wait flags that feed the decoder's mem_wait stall.

## Interface
- NCH, 3: number of requester channels (2..8)
- AW, 16: address width
- DW, 8: data width
- RR_MODE, 0: 0 = fixed priority (channel 0 highest), 1 = round-robin
- TIMEOUT, 0: max cycles waiting for dack_i; 0 disables the timeout

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_i  in  NCH  per-channel request level
- we_i  in  NCH  per-channel write enable (1 = write)
- adr_i  in  NCH*AW  per-channel address, channel k at [k*AW +: AW]
- wdat_i  in  NCH*DW  per-channel write data, same packing
- wait_o  out  NCH  req_i[k] & ~done_o[k]; combinational stall to requester
- done_o  out  NCH  one-cycle completion pulse, one-hot
- err_o  out  NCH  one-cycle timeout pulse, one-hot
- rdat_o  out  DW  read data, valid in the done_o cycle and held until the next read completes
- dstb_o  out  1  external strobe
- dwe_o  out  1  external write enable
- dadr_o  out  AW  external address
- ddat_o  out  DW  external write data
- dack_i  in  1  external acknowledge
- ddat_i  in  DW  external read data, valid with dack_i

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when any req_i is set, the picker selects a channel. On the edge, register gidx, dadr_o, dwe_o, ddat_o; set dstb_o=1; go to ACCESS.
- ACCESS: dstb_o held at 1; bus outputs stable. When dack_i=1: dstb_o<=0; for reads rdat_o<=ddat_i; done_o[gidx]<=1; go to DONE.
- Timeout (TIMEOUT>0): a counter counts ACCESS cycles without ack. When the count reaches TIMEOUT: dstb_o<=0; err_o[gidx]<=1; done_o[gidx]<=1; rdat_o unchanged; go to DONE. If dack_i arrives in the same cycle as the limit, the ack wins and err_o stays 0.
- DONE: one bus-turnaround cycle. Pulses clear next cycle; return to IDLE.
- Fixed mode: lowest-index active request wins.
- Round-robin mode: search starts at last_grant+1 modulo NCH. last_grant updates only on grant.
- req_i dropped during ACCESS: no abort; the transaction completes and done_o still pulses.
- dack_i in IDLE or DONE is ignored.
- A requester that still holds req_i after done_o re-enters arbitration in the next IDLE.

## Timing
- Reset values: state=IDLE, dstb_o=0, dwe_o=0, dadr_o=0, ddat_o=0, rdat_o=0, done_o=0, err_o=0, timeout counter=0, last_grant=NCH-1 (so channel 0 wins first in RR mode).
- Reset mid-transaction: bus released on the reset edge; no done_o or err_o pulse.
- Minimum latency, with req at cycle 0 in IDLE and dack_i at cycle 1: dstb_o high at cycle 1, done_o and rdat_o at cycle 2, IDLE at cycle 3. Throughput is one access per 3 cycles.
- Each added wait cycle of dack_i adds one cycle of latency.
- wait_o has no register stage; it is the only combinational output.

## Structure
- Package xram_arb_pkg holds:
  - the state enum (IDLE/ACCESS/DONE)
  - RR_MODE constants
  - the $clog2(NCH) index width function
- Sub-module xram_rr_pick: purely combinational. Takes req, last_grant and mode; returns valid and idx. It is reused by the future IROM fetch arbiter.
- The top level holds the FSM, timeout counter, output registers and unpacking.

## Test plan
- Single read, fixed mode: req_i=001, adr ch0=0x1234, dack_i one cycle after the strobe with ddat_i=0xA5 -> dadr_o=0x1234, dwe_o=0, done_o=001 at cycle 2, rdat_o=0xA5.
- Contention, fixed mode: req_i=110 held -> ch1 is served twice before ch2 while ch1 stays requested.
- Contention, RR mode: req_i=111 held, ack always immediate -> grant order 0,1,2,0; done_o every 3 cycles.
- Write with 4-cycle ack delay: ch2 we=1, adr=0x00FF, wdat=0x3C -> dstb_o high for 4 cycles with dwe_o=1 and ddat_o=0x3C; done_o=100; rdat_o unchanged.
- Timeout, TIMEOUT=5, no ack -> err_o and done_o for the granted channel after 5 ACCESS cycles; dstb_o=0. Ack arriving exactly at the limit -> err_o=0.
- rst asserted during ACCESS -> next cycle dstb_o=0, no pulses, state IDLE. A stray dack_i in IDLE produces no done_o.
